// File: rtl/spi_xfer_ctrl.sv
// Single-frame SPI master: IDLE -> SETUP -> SHIFT -> HOLD, all four CPOL/CPHA modes, MSB first.
// Latency 1+(D+1)*(1+2*DATA_W+CS_HOLD) cycles to done_o; start_i is ignored (not queued) while busy.
module spi_xfer_ctrl #(
    parameter int DATA_W  = 8,
    parameter int CS_HOLD = 1
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic [7:0]        clk_div_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              miso_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              sclk_o,
    output logic              mosi_o,
    output logic              cs_n_o
);

    localparam int BCW = $clog2(2 * DATA_W) + 1;
    localparam logic [BCW-1:0] LAST_EDGE = BCW'(2 * DATA_W - 1);
    localparam logic [3:0]     HOLD_LAST = 4'(CS_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [7:0]        div_q;
    logic [7:0]        hp_cnt_q;
    logic              cpol_q;
    logic              cpha_q;
    logic [DATA_W-1:0] tx_sr_q;
    logic [DATA_W-1:0] rx_sr_q;
    logic [BCW-1:0]    bit_cnt_q;
    logic [3:0]        hold_cnt_q;

    logic tick;
    logic lead_edge;
    logic accept;
    logic last_edge;
    logic hold_done;

    assign tick      = (state_q != IDLE) && (hp_cnt_q == div_q);
    // Edges are numbered from 1, so an even count means the upcoming edge is odd (leading).
    assign lead_edge = ~bit_cnt_q[0];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        last_edge = 1'b0;
        hold_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    accept  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick && (bit_cnt_q == LAST_EDGE)) begin
                    last_edge = 1'b1;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (tick && (hold_cnt_q == HOLD_LAST)) begin
                    hold_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            div_q      <= '0;
            hp_cnt_q   <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            bit_cnt_q  <= '0;
            hold_cnt_q <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            rx_data_o  <= '0;
            sclk_o     <= 1'b0;
            mosi_o     <= 1'b0;
            cs_n_o     <= 1'b1;
        end else begin
            done_o <= hold_done;
            if (accept) begin
                div_q      <= clk_div_i;
                cpol_q     <= cpol_i;
                cpha_q     <= cpha_i;
                hp_cnt_q   <= '0;
                bit_cnt_q  <= '0;
                hold_cnt_q <= '0;
                rx_sr_q    <= '0;
                busy_o     <= 1'b1;
                cs_n_o     <= 1'b0;
                sclk_o     <= cpol_i;
                // CPHA=0 must have the MSB on the wire before the first (sampling) edge.
                if (!cpha_i) begin
                    mosi_o  <= tx_data_i[DATA_W-1];
                    tx_sr_q <= tx_data_i << 1;
                end else begin
                    mosi_o  <= 1'b0;
                    tx_sr_q <= tx_data_i;
                end
            end else if (state_q == IDLE) begin
                hp_cnt_q <= '0;
                sclk_o   <= cpol_i;
                mosi_o   <= 1'b0;
            end else begin
                hp_cnt_q <= tick ? 8'd0 : hp_cnt_q + 8'd1;
                if (state_q == SETUP || state_q == HOLD) begin
                    sclk_o <= cpol_q;
                end
                if (state_q == SHIFT && tick) begin
                    sclk_o    <= ~sclk_o;
                    bit_cnt_q <= bit_cnt_q + BCW'(1);
                    // Shift edge is leading for CPHA=1 and trailing for CPHA=0.
                    if (lead_edge == cpha_q) begin
                        if (!last_edge) begin
                            mosi_o  <= tx_sr_q[DATA_W-1];
                            tx_sr_q <= tx_sr_q << 1;
                        end
                    end else begin
                        rx_sr_q <= {rx_sr_q[DATA_W-2:0], miso_i};
                    end
                end
                if (state_q == HOLD && tick) begin
                    hold_cnt_q <= hold_cnt_q + 4'd1;
                end
                if (hold_done) begin
                    hold_cnt_q <= '0;
                    bit_cnt_q  <= '0;
                    busy_o     <= 1'b0;
                    cs_n_o     <= 1'b1;
                    mosi_o     <= 1'b0;
                    rx_data_o  <= rx_sr_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Scoreboard bench for spi_xfer_ctrl: frames are queued with expected rx/latency when driven
// and checked, together with SCLK edge count, half-period length and MOSI edge alignment, on done_o.
module tb_spi_xfer_ctrl;
    localparam int W   = 8;
    localparam int CSH = 1;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [7:0]   clk_div;
    logic         cpol;
    logic         cpha;
    logic         start;
    logic [W-1:0] tx_data;
    logic         miso;
    logic         busy;
    logic         done;
    logic [W-1:0] rx_data;
    logic         sclk;
    logic         mosi;
    logic         cs_n;
    int           miso_mode;

    // 0: loop back MOSI, 1: held high, 2: held low
    assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1);

    spi_xfer_ctrl #(
        .DATA_W (W),
        .CS_HOLD(CSH)
    ) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n),
        .clk_div_i(clk_div),
        .cpol_i   (cpol),
        .cpha_i   (cpha),
        .start_i  (start),
        .tx_data_i(tx_data),
        .miso_i   (miso),
        .busy_o   (busy),
        .done_o   (done),
        .rx_data_o(rx_data),
        .sclk_o   (sclk),
        .mosi_o   (mosi),
        .cs_n_o   (cs_n)
    );

    always #5 clk = ~clk;

    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] rx;
        int           acc;
        int           lat;
        int           hp;
        bit           cpol;
        bit           cpha;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] last_rx = '0;

    int   m_edges;
    int   m_last;
    int   m_hpmin;
    int   m_hpmax;
    int   m_bad;
    bit   m_first;
    logic p_sclk;
    logic p_cs;
    logic p_mosi;

    task automatic mon_clear();
        m_edges = 0;
        m_hpmin = 1 << 30;
        m_hpmax = 0;
        m_bad   = 0;
        m_first = 1'b1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        int   hp;
        bit   ok;
        if (!reset_n) begin
            mon_clear();
        end else begin
            if (!cs_n && !p_cs) begin
                if (sclk != p_sclk) begin
                    if (!m_first) begin
                        hp = ecnt - m_last;
                        if (hp < m_hpmin) m_hpmin = hp;
                        if (hp > m_hpmax) m_hpmax = hp;
                    end
                    m_first = 1'b0;
                    m_last  = ecnt;
                    m_edges++;
                end
                if (mosi != p_mosi && sb.size() > 0) begin
                    ok = (sclk != p_sclk) &&
                         (sb[0].cpha ? (sclk != sb[0].cpol) : (sclk == sb[0].cpol));
                    if (!ok) m_bad++;
                end
            end
            if (done) begin
                if (sb.size() == 0) begin
                    check("no_extra_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rx_data", 32'(rx_data), 32'(e.rx));
                    check("done_latency", 32'(ecnt - e.acc), 32'(e.lat));
                    check("sclk_edges", 32'(m_edges), 32'(2 * W));
                    check("half_period_min", 32'(m_hpmin), 32'(e.hp));
                    check("half_period_max", 32'(m_hpmax), 32'(e.hp));
                    check("mosi_edge_align", 32'(m_bad), 32'd0);
                end
                mon_clear();
            end
        end
        p_sclk = sclk;
        p_cs   = cs_n;
        p_mosi = mosi;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called #1 after a clock edge while the DUT is known to be in IDLE.
    task automatic start_frame(input logic [7:0] tx, input logic [7:0] div, input bit cp,
                               input bit ch, input int mm);
        exp_t e;
        check("rx_hold", 32'(rx_data), 32'(last_rx));
        tx_data   = tx;
        clk_div   = div;
        cpol      = cp;
        cpha      = ch;
        miso_mode = mm;
        start     = 1'b1;
        e.rx      = (mm == 0) ? tx : ((mm == 1) ? 8'hFF : 8'h00);
        e.acc     = ecnt;
        e.lat     = 1 + (int'(div) + 1) * (1 + 2 * W + CSH);
        e.hp      = int'(div) + 1;
        e.cpol    = cp;
        e.cpha    = ch;
        sb.push_back(e);
        last_rx = e.rx;
        step(1);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("cs_lo_after_start", 32'(cs_n), 32'd0);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            step(1);
            n++;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    initial begin
        int n;
        reset_n   = 1'b1;
        start     = 1'b0;
        tx_data   = '0;
        clk_div   = '0;
        cpol      = 1'b0;
        cpha      = 1'b0;
        miso_mode = 0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rx", 32'(rx_data), 32'd0);
        step(3);
        reset_n = 1'b1;

        // IDLE: sclk tracks live cpol one cycle later
        cpol = 1'b1;
        step(1);
        check("idle_sclk_cpol1", 32'(sclk), 32'd1);
        check("idle_mosi", 32'(mosi), 32'd0);
        cpol = 1'b0;
        step(1);
        check("idle_sclk_cpol0", 32'(sclk), 32'd0);

        // Reset at SCLK edge 7 aborts the frame
        start_frame(8'h5A, 8'd1, 1'b0, 1'b0, 0);
        n = 0;
        while (m_edges < 7 && n < 200) begin
            step(1);
            n++;
        end
        check("edge7_reached", 32'(m_edges), 32'd7);
        reset_n = 1'b0;
        #1;
        check("abort_cs_n", 32'(cs_n), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sclk", 32'(sclk), 32'd0);
        check("abort_rx", 32'(rx_data), 32'd0);
        sb.delete();
        last_rx = '0;
        step(3);
        reset_n = 1'b1;
        step(10);
        check("rx_after_abort", 32'(rx_data), 32'd0);
        check("no_done_after_abort", 32'(done), 32'd0);

        // Mode 0, D=1, loopback: 37-cycle latency
        start_frame(8'hA5, 8'd1, 1'b0, 1'b0, 0);
        wait_done(100);
        step(2);

        // Mode 3, D=0, miso high
        cpol = 1'b1;
        step(1);
        check("mode3_idle_hi", 32'(sclk), 32'd1);
        start_frame(8'h3C, 8'd0, 1'b1, 1'b1, 1);
        wait_done(60);
        step(1);
        check("mode3_idle_hi_after", 32'(sclk), 32'd1);
        step(1);

        // start while busy plus live config changes are ignored
        start_frame(8'h96, 8'd2, 1'b0, 1'b0, 0);
        step(10);
        tx_data = 8'h11;
        clk_div = 8'd0;
        cpol    = 1'b1;
        cpha    = 1'b1;
        start   = 1'b1;
        step(1);
        start = 1'b0;
        check("busy_mid_frame", 32'(busy), 32'd1);
        wait_done(200);
        step(30);

        // Back-to-back: second start in the done cycle
        start_frame(8'h81, 8'd1, 1'b1, 1'b0, 0);
        wait_done(100);
        check("b2b_gap_cs_hi", 32'(cs_n), 32'd1);
        start_frame(8'h7E, 8'd0, 1'b0, 1'b1, 0);
        wait_done(60);
        step(2);

        // D=255, mode 1
        start_frame(8'hC3, 8'd255, 1'b0, 1'b1, 0);
        wait_done(5000);
        step(2);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_xfer_ctrl.md
SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8: frame width in bits, MSB first.
REQ-002 SHALL have parameter CS_HOLD, default 1: SCLK half-periods between the last SCLK edge and cs_n_o deassert; range 1..15.
REQ-003 SHALL have port clk_i, input, 1: system clock.
REQ-004 SHALL have port reset_n_i, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port clk_div_i, input, 8: half-period divider; one half-period lasts clk_div_i+1 clk_i cycles.
REQ-006 SHALL have port cpol_i, input, 1: SCLK idle level.
REQ-007 SHALL have port cpha_i, input, 1: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-008 SHALL have port start_i, input, 1: transfer request, sampled only in IDLE.
REQ-009 SHALL have port tx_data_i, input, DATA_W: frame to send.
REQ-010 SHALL have port miso_i, input, 1: serial in.
REQ-011 SHALL have port busy_o, output, 1: high from the cycle after start is accepted until done_o.
REQ-012 SHALL have port done_o, output, 1: single-cycle completion pulse.
REQ-013 SHALL have port rx_data_o, output, DATA_W: last received frame.
REQ-014 SHALL have ports sclk_o, mosi_o and cs_n_o, output, 1 each: SPI clock, serial out and active-low chip select, all registered.

Function
REQ-015 SHALL implement states IDLE, SETUP, SHIFT and HOLD.
REQ-016 On start_i in IDLE, SHALL latch tx_data_i, clk_div_i, cpol_i and cpha_i, then enter SETUP with cs_n_o=0 and busy_o=1 on the next cycle.
REQ-017 SHALL keep changes on clk_div_i, cpol_i, cpha_i and tx_data_i after acceptance from affecting the current transfer.
REQ-018 SHALL ignore start_i outside IDLE; no queuing.
REQ-019 SHALL use a half-period counter that runs 0..latched divider, produces a tick on reaching the divider and wraps to 0; the counter SHALL be held at 0 in IDLE.
REQ-020 SHALL make the divider value 0 produce a tick every cycle.
REQ-021 SETUP SHALL last exactly 1 half-period with sclk_o at CPOL.
REQ-022 If CPHA=0, mosi_o SHALL present the MSB from entry into SETUP.
REQ-023 SHIFT SHALL toggle sclk_o on each tick for exactly 2*DATA_W edges; odd edges are leading edges and even edges are trailing edges.
REQ-024 With CPHA=0, SHALL sample miso_i on leading edges and shift mosi_o on trailing edges, except the final trailing edge.
REQ-025 With CPHA=1, SHALL shift mosi_o on leading edges, starting with the MSB at edge 1, and sample miso_i on trailing edges.
REQ-026 SHALL use a bit counter of width clog2(2*DATA_W)+1 that does not wrap within a frame.
REQ-027 HOLD SHALL last CS_HOLD half-periods with sclk_o at CPOL.
REQ-028 On HOLD completion, in the same edge, SHALL set cs_n_o=1, busy_o=0, done_o=1, load rx_data_o with the received frame and return to IDLE.
REQ-029 SHALL assert done_o exactly 1+(D+1)*(1+2*DATA_W+CS_HOLD) cycles after the start-accept cycle, where D is the latched divider.
REQ-030 start_i in the done_o cycle SHALL be accepted, allowing back-to-back frames with exactly one IDLE cycle, cs_n_o high, between them.
REQ-031 In IDLE, sclk_o SHALL follow the live cpol_i one cycle later, and mosi_o SHALL be 0.
REQ-032 rx_data_o SHALL hold its value between done_o pulses.

Reset
REQ-033 On reset_n_i low, asynchronously: state=IDLE, cs_n_o=1, sclk_o=0, mosi_o=0, busy_o=0, done_o=0, rx_data_o=0, all counters 0.
REQ-034 Reset mid-transfer SHALL abort with no done_o pulse and no rx_data_o update.
REQ-035 After reset release, the first accepted start_i SHALL behave identically to a start after power-up.

Verification
REQ-036 SHALL cover: mode 0, DATA_W=8, D=1, tx=0xA5, miso looped to mosi -> 16 sclk edges, each half-period 2 cycles, done_o 37 cycles after start, rx_data_o=0xA5.
REQ-037 SHALL cover: mode 3 (cpol=1, cpha=1), D=0, tx=0x3C, miso held 1 -> sclk idles high, done_o at cycle 19, rx_data_o=0xFF, mosi changes only on falling edges.
REQ-038 SHALL cover: start_i pulsed while busy, plus clk_div_i changed mid-frame -> ignored, timing unchanged, exactly one done_o.
REQ-039 SHALL cover: back-to-back start_i in the done_o cycle -> second frame begins, cs_n_o high for exactly 1 cycle.
REQ-040 SHALL cover: reset_n_i low at edge 7 of the frame -> cs_n_o=1 immediately, no done_o, rx_data_o stays at its prior value of 0.
REQ-041 SHALL cover: D=255, mode 1 -> each half-period 256 cycles, counter wraps with no overflow glitch, done_o at 1+256*18.
